// File: rtl/identity_pkg.sv
// Field layout of the 336-bit identity status word plus shared helpers.
// Pure declarations: no latency and no flow control.
package identity_pkg;

  localparam int Y_W    = 336;
  localparam int IN_W   = 72;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 32;
  localparam int HASH_W = 38;

  localparam int SUM_W  = 27;
  localparam int MUL_W  = 31;
  localparam int XOR_W  = 15;
  localparam int MAX_W  = 26;
  localparam int POP_W  = 7;

  localparam int D1_LSB   = 0;
  localparam int D2_LSB   = 72;
  localparam int SUM_LSB  = 144;
  localparam int MUL_LSB  = 171;
  localparam int XOR_LSB  = 202;
  localparam int ACC_LSB  = 217;
  localparam int CNT_LSB  = 233;
  localparam int MAX_LSB  = 265;
  localparam int POP_LSB  = 291;
  localparam int HASH_LSB = 298;

  // Declared MSB first so the packed layout matches the y bit map.
  typedef struct packed {
    logic [HASH_W-1:0] hash;
    logic [POP_W-1:0]  pop;
    logic [MAX_W-1:0]  max_v;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [XOR_W-1:0]  xr;
    logic [MUL_W-1:0]  mul;
    logic [SUM_W-1:0]  sum;
    logic [IN_W-1:0]   d2;
    logic [IN_W-1:0]   d1;
  } status_t;

  function automatic logic [HASH_W-1:0] hash_next(
    input logic [HASH_W-1:0] h,
    input logic [IN_W-1:0]   in_v
  );
    return {h[HASH_W-2:0], h[HASH_W-1]} ^ in_v[HASH_W-1:0] ^ {4'b0, in_v[IN_W-1:HASH_W]};
  endfunction

endpackage

// File: rtl/identity_popcnt72.sv
// Combinational 72-bit popcount (nibble counts summed in a small tree).
// Latency 0; no flow control, the caller registers the result.
module identity_popcnt72
  import identity_pkg::*;
(
  input  logic [IN_W-1:0]  i_vec,
  output logic [POP_W-1:0] o_cnt
);

  localparam int NIB_N = IN_W / 4;

  logic [2:0] w_nib [NIB_N];
  logic [4:0] w_grp [NIB_N/6];

  always_comb begin
    for (int n = 0; n < NIB_N; n++) begin
      w_nib[n] = {2'b0, i_vec[4*n]}   + {2'b0, i_vec[4*n+1]}
               + {2'b0, i_vec[4*n+2]} + {2'b0, i_vec[4*n+3]};
    end
  end

  // Six nibbles per group keeps every group sum within 5 bits (max 24).
  always_comb begin
    for (int g = 0; g < NIB_N/6; g++) begin
      w_grp[g] = '0;
      for (int k = 0; k < 6; k++) begin
        w_grp[g] = w_grp[g] + {2'b0, w_nib[6*g+k]};
      end
    end
  end

  always_comb begin
    o_cnt = '0;
    for (int g = 0; g < NIB_N/6; g++) begin
      o_cnt = o_cnt + {2'b0, w_grp[g]};
    end
  end

endmodule

// File: rtl/identity_top.sv
// Registered fuzz-harness core: y = delays, arithmetic, acc, counter, popcount, optional hash (SIG_HASH_EN).
// Latency 1 cycle (delay-2 field: 2); no backpressure, a new sample is taken every clk edge.
module identity_top
  import identity_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic        [5:0] wire3,
  input  logic       [14:0] wire2,
  input  logic       [24:0] wire1,
  input  logic       [25:0] wire0,
  output logic [Y_W-1:0]    y
);

  status_t r_y;

  logic [IN_W-1:0]   w_in;
  logic [SUM_W-1:0]  w_sum;
  logic [MUL_W-1:0]  w_a3;
  logic [MUL_W-1:0]  w_c1;
  logic [MUL_W-1:0]  w_mul;
  logic [XOR_W-1:0]  w_xor;
  logic [MAX_W-1:0]  w_c1_26;
  logic [MAX_W-1:0]  w_max;
  logic [POP_W-1:0]  w_pop;
  logic [HASH_W-1:0] w_hash;

  assign w_in = {wire3, wire2, wire1, wire0};

  assign w_sum = {wire0[25], wire0} + {{2{wire1[24]}}, wire1};

  // Operands sign-extended to the full product width so no bits are lost.
  assign w_a3  = {{(MUL_W-6){wire3[5]}}, wire3};
  assign w_c1  = {{(MUL_W-25){wire1[24]}}, wire1};
  assign w_mul = $unsigned($signed(w_a3) * $signed(w_c1));

  assign w_xor = wire2 ^ wire0[XOR_W-1:0];

  assign w_c1_26 = {wire1[24], wire1};
  assign w_max   = ($signed(wire0) >= $signed(w_c1_26)) ? wire0 : w_c1_26;

  identity_popcnt72 u_popcnt (
    .i_vec (w_in),
    .o_cnt (w_pop)
  );

`ifdef SIG_HASH_EN
  assign w_hash = hash_next(r_y.hash, w_in);
`else
  assign w_hash = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y <= '0;
    end else begin
      r_y.d1    <= w_in;
      r_y.d2    <= r_y.d1;
      r_y.sum   <= w_sum;
      r_y.mul   <= w_mul;
      r_y.xr    <= w_xor;
      r_y.acc   <= r_y.acc + {1'b0, wire2};
      r_y.cnt   <= r_y.cnt + CNT_W'(1);
      r_y.max_v <= w_max;
      r_y.pop   <= w_pop;
      r_y.hash  <= w_hash;
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_identity_top.sv
// Bench for identity_top: directed vector table, reset sequences, then randomized run vs a reference model.
module tb_identity_top;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   wire3;
  logic [14:0]  wire2;
  logic [24:0]  wire1;
  logic [25:0]  wire0;
  logic [335:0] y;

  int n_vec = 0;
  int n_err = 0;

  identity_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wire3 (wire3),
    .wire2 (wire2),
    .wire1 (wire1),
    .wire0 (wire0),
    .y     (y)
  );

  always #5 clk = ~clk;

  // Reference model: history queue of inputs since reset, plain integer arithmetic.
  logic [71:0]  m_q [$];
  longint       m_acc;
  longint       m_cnt;
  logic [37:0]  m_h;
  logic [335:0] m_exp;

  task automatic model_edge();
    logic [71:0] in_v, d2;
    longint a3, c1, d0, s, p, mx;
    logic [6:0] pc;
    if (!rst_n) begin
      m_q.delete();
      m_acc = 0;
      m_cnt = 0;
      m_h   = '0;
      m_exp = '0;
    end else begin
      in_v = {wire3, wire2, wire1, wire0};
      m_q.push_back(in_v);
      if (m_q.size() > 2) void'(m_q.pop_front());
      d2 = (m_q.size() == 2) ? m_q[0] : 72'h0;
      a3 = longint'($signed(wire3));
      c1 = longint'($signed(wire1));
      d0 = longint'($signed(wire0));
      s  = d0 + c1;
      p  = a3 * c1;
      mx = (d0 >= c1) ? d0 : c1;
      pc = 7'($countones(in_v));
      m_acc = m_acc + longint'(wire2);
      m_cnt = m_cnt + 1;
`ifdef SIG_HASH_EN
      m_h = {m_h[36:0], m_h[37]} ^ in_v[37:0] ^ {4'b0, in_v[71:38]};
`endif
      m_exp = {m_h, pc, mx[25:0], m_cnt[31:0], m_acc[15:0],
               wire2 ^ wire0[14:0], p[30:0], s[26:0], d2, in_v};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [127:0] fld(input logic [335:0] v, input int lsb, input int wd);
    logic [335:0] t;
    logic [127:0] r;
    t = v >> lsb;
    r = '0;
    for (int i = 0; i < wd; i++) r[i] = t[i];
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_y(input string nm, input logic [335:0] exp);
    n_vec++;
    if (y !== exp) begin
      n_err++;
      $display("FAIL %s: y got %0h expected %0h", nm, y, exp);
    end
  endtask

  task automatic rand_inputs();
    logic [31:0] r;
    r = $urandom; wire3 = r[5:0];
    r = $urandom; wire2 = r[14:0];
    r = $urandom; wire1 = r[24:0];
    r = $urandom; wire0 = r[25:0];
    // Occasionally force extremes to hit sign and tie boundaries.
    if ($urandom_range(0, 7) == 0) begin
      wire3 = $urandom_range(0, 1) ? 6'h20 : 6'h1F;
      wire1 = $urandom_range(0, 1) ? 25'h1000000 : 25'h1FFFFFF;
      wire0 = {wire1[24], wire1};
    end
  endtask

  typedef struct {
    bit          adv;
    bit          rst;
    logic [5:0]  w3;
    logic [14:0] w2;
    logic [24:0] w1;
    logic [25:0] w0;
    string       nm;
    int          lsb;
    int          wd;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input bit adv, input logic [5:0] w3, input logic [14:0] w2,
                     input logic [24:0] w1, input logic [25:0] w0, input string nm,
                     input int lsb, input int wd, input logic [127:0] exp);
    vec_t v;
    v.adv = adv; v.rst = 1'b1; v.w3 = w3; v.w2 = w2; v.w1 = w1; v.w0 = w0;
    v.nm = nm; v.lsb = lsb; v.wd = wd; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0;
    rand_inputs();

    // Rows with adv=0 check another field of the same cycle without clocking.
    add(1, 6'h3F, 15'h7FFF, 25'h3,       26'h0,       "cnt_first", 233, 32, 128'h1);
    add(0, 6'h3F, 15'h7FFF, 25'h3,       26'h0,       "mul_neg",   171, 31, 128'h7FFFFFFD);
    add(0, 6'h3F, 15'h7FFF, 25'h3,       26'h0,       "acc_1",     217, 16, 128'h7FFF);
    add(1, 6'h00, 15'h7FFF, 25'h1FFFFFF, 26'h3FFFFFF, "sum_neg",   144, 27, 128'h7FFFFFE);
    add(0, 6'h00, 15'h7FFF, 25'h1FFFFFF, 26'h3FFFFFF, "max_tie",   265, 26, 128'h3FFFFFF);
    add(0, 6'h00, 15'h7FFF, 25'h1FFFFFF, 26'h3FFFFFF, "acc_2",     217, 16, 128'hFFFE);
    add(1, 6'h00, 15'h7FFF, 25'h3,       26'h3FFFFFB, "max_mix",   265, 26, 128'h3);
    add(0, 6'h00, 15'h7FFF, 25'h3,       26'h3FFFFFB, "acc_3",     217, 16, 128'h7FFD);
    add(0, 6'h00, 15'h7FFF, 25'h3,       26'h3FFFFFB, "xor",       202, 15, 128'h4);
    add(0, 6'h00, 15'h7FFF, 25'h3,       26'h3FFFFFB, "cnt_3",     233, 32, 128'h3);
    add(1, 6'h3F, 15'h7FFF, 25'h1FFFFFF, 26'h3FFFFFF, "pop_ones",  291, 7,  128'h48);
    add(0, 6'h3F, 15'h7FFF, 25'h1FFFFFF, 26'h3FFFFFF, "acc_wrap",  217, 16, 128'hFFFC);
    add(0, 6'h3F, 15'h7FFF, 25'h1FFFFFF, 26'h3FFFFFF, "d1_ones",   0,   72, {72{1'b1}});
    add(0, 6'h3F, 15'h7FFF, 25'h1FFFFFF, 26'h3FFFFFF, "d2_lag",    72,  72,
        {6'h00, 15'h7FFF, 25'h0000003, 26'h3FFFFFB});

    // Two reset edges with random inputs.
    for (int k = 0; k < 2; k++) begin
      rand_inputs();
      step();
      check_y("reset_hold", 336'h0);
    end

    foreach (tbl[i]) begin
      if (tbl[i].adv) begin
        rst_n = tbl[i].rst;
        wire3 = tbl[i].w3; wire2 = tbl[i].w2; wire1 = tbl[i].w1; wire0 = tbl[i].w0;
        step();
        check_y({"model_", tbl[i].nm}, m_exp);
      end
      check(tbl[i].nm, fld(y, tbl[i].lsb, tbl[i].wd), tbl[i].exp);
    end

    // Mid-run reset for one cycle, then release.
    for (int k = 0; k < 5; k++) begin
      rand_inputs();
      step();
      check_y("pre_rst", m_exp);
    end
    rst_n = 1'b0;
    rand_inputs();
    step();
    check_y("mid_rst", 336'h0);
    rst_n = 1'b1;
    wire3 = 6'h01; wire2 = 15'h1234; wire1 = 25'h5; wire0 = 26'h7;
    step();
    check("rel_cnt", fld(y, 233, 32), 128'h1);
    check("rel_acc", fld(y, 217, 16), 128'h1234);
    check("rel_d2",  fld(y, 72, 72),  128'h0);
    check_y("rel_model", m_exp);

    // Randomized run with sparse resets.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      rand_inputs();
      step();
      check_y("rand", m_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
